// File: rtl/fpc_pkg.sv
// fpc_pkg: shared types and constants for the fetch PC unit.
//   fpc_pred_entry_t : one in-flight fetch record {pc, pred_taken, pred_target}
//   INSTR_BYTES      : sequential fetch stride
package fpc_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } fpc_pred_entry_t;

  // Sequential successor of a fetch PC (wraps modulo 2^32).
  function automatic logic [31:0] fpc_next_seq(input logic [31:0] pc);
    return pc + 32'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fpc_pred_fifo.sv
// fpc_pred_fifo: in-order queue of fetched PCs and their BTB predictions,
// held until execute retires them.
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   flush_i             drop all entries (beats push/pop in the same cycle)
//   push_i/push_data_i  enqueue; accepted when not full, or when full and popping
//   pop_i               dequeue head (ignored while empty)
//   head_o              oldest entry
//   full_o, empty_o     occupancy flags
module fpc_pred_fifo
  import fpc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  fpc_pred_entry_t push_data_i,
  input  logic            pop_i,
  output fpc_pred_entry_t head_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int AW = $clog2(DEPTH);

  fpc_pred_entry_t mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A full queue can still accept a push when the head leaves this cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage PC generator ahead of the branch target buffer.
// Drives the fetch PC, follows the BTB prediction, records every fetch in an
// in-order queue, checks each retired instruction against its prediction,
// redirects fetch on a mispredict and emits the BTB update.
// Ports:
//   fpc_clk, fpc_reset        clock, synchronous active-low reset
//   fpc_stall                 decode not ready
//   fpc_btb_valid_pred/target BTB prediction for fpc_pc (same cycle)
//   fpc_retire_*              retirement of the oldest queued instruction
//   fpc_pc, fpc_fetch_valid   fetch PC and "fetched + queued this cycle"
//   fpc_redirect              registered mispredict pulse
//   fpc_btb_write/branch_taken/new_pc/data  registered BTB update
// Optional: define FPC_PERF_CNT_EN to add saturating fpc_branch_cnt and
// fpc_mispred_cnt outputs.
module fetch_pc_unit
  import fpc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        fpc_clk,
  input  logic        fpc_reset,
  input  logic        fpc_stall,
  input  logic        fpc_btb_valid_pred,
  input  logic [31:0] fpc_btb_target,
  input  logic        fpc_retire_valid,
  input  logic        fpc_retire_is_branch,
  input  logic        fpc_retire_taken,
  input  logic [31:0] fpc_retire_target,
  output logic [31:0] fpc_pc,
  output logic        fpc_fetch_valid,
  output logic        fpc_redirect,
  output logic        fpc_btb_write,
  output logic        fpc_btb_branch_taken,
  output logic [31:0] fpc_btb_new_pc,
  output logic [31:0] fpc_btb_data
`ifdef FPC_PERF_CNT_EN
  ,
  output logic [31:0] fpc_branch_cnt,
  output logic [31:0] fpc_mispred_cnt
`endif
);

  logic [31:0]     pc_q, pc_d;
  logic            run_q;
  logic            redirect_q;
  logic            btb_write_q, btb_taken_q;
  logic [31:0]     btb_new_pc_q, btb_data_q;

  fpc_pred_entry_t head, push_entry;
  logic            q_full, q_empty;
  logic            pop, mispredict, redirect_now;
  logic [31:0]     head_seq, correct_pc, actual_target;

  fpc_pred_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk_i       (fpc_clk),
    .rst_ni      (fpc_reset),
    .flush_i     (redirect_now),
    .push_i      (fpc_fetch_valid),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  // ---- retire check ----
  assign pop      = fpc_retire_valid & ~q_empty;
  assign head_seq = fpc_next_seq(head.pc);

  // A non-branch should never have been predicted taken; a branch must match
  // both direction and (when taken) target.
  always_comb begin
    mispredict = 1'b0;
    if (fpc_retire_is_branch)
      mispredict = (fpc_retire_taken != head.pred_taken) ||
                   (fpc_retire_taken && (fpc_retire_target != head.pred_target));
    else
      mispredict = head.pred_taken;
  end

  assign redirect_now  = pop & mispredict;
  assign actual_target = fpc_retire_taken ? fpc_retire_target : head_seq;
  assign correct_pc    = (fpc_retire_is_branch && fpc_retire_taken) ? fpc_retire_target
                                                                    : head_seq;

  // ---- fetch ----
  assign fpc_fetch_valid = run_q & ~fpc_stall & (~q_full | pop) & ~redirect_now;
  assign push_entry      = '{pc: pc_q, pred_taken: fpc_btb_valid_pred,
                             pred_target: fpc_btb_target};

  always_comb begin
    pc_d = pc_q;
    if (redirect_now)
      pc_d = correct_pc;
    else if (fpc_fetch_valid)
      pc_d = fpc_btb_valid_pred ? fpc_btb_target : fpc_next_seq(pc_q);
  end

  always_ff @(posedge fpc_clk) begin
    if (!fpc_reset) begin
      pc_q         <= RESET_PC;
      run_q        <= 1'b0;
      redirect_q   <= 1'b0;
      btb_write_q  <= 1'b0;
      btb_taken_q  <= 1'b0;
      btb_new_pc_q <= '0;
      btb_data_q   <= '0;
    end else begin
      pc_q        <= pc_d;
      run_q       <= 1'b1;
      redirect_q  <= redirect_now;
      btb_write_q <= pop & fpc_retire_is_branch;
      if (pop && fpc_retire_is_branch) begin
        btb_taken_q  <= fpc_retire_taken;
        btb_new_pc_q <= head.pc;
        btb_data_q   <= actual_target;
      end
    end
  end

  assign fpc_pc               = pc_q;
  assign fpc_redirect         = redirect_q;
  assign fpc_btb_write        = btb_write_q;
  assign fpc_btb_branch_taken = btb_taken_q;
  assign fpc_btb_new_pc       = btb_new_pc_q;
  assign fpc_btb_data         = btb_data_q;

`ifdef FPC_PERF_CNT_EN
  logic [31:0] branch_cnt_q, mispred_cnt_q;

  always_ff @(posedge fpc_clk) begin
    if (!fpc_reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (pop && fpc_retire_is_branch && branch_cnt_q != 32'hFFFF_FFFF)
        branch_cnt_q <= branch_cnt_q + 1'b1;
      if (redirect_now && mispred_cnt_q != 32'hFFFF_FFFF)
        mispred_cnt_q <= mispred_cnt_q + 1'b1;
    end
  end

  assign fpc_branch_cnt  = branch_cnt_q;
  assign fpc_mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, pred, r_valid, r_br, r_taken;
  logic [31:0] btb_tgt, r_tgt;
  logic [31:0] pc, new_pc, data;
  logic        fv, redir, bw, btaken;
`ifdef FPC_PERF_CNT_EN
  logic [31:0] br_cnt, mp_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(32'h0), .QDEPTH(4)) dut (
    .fpc_clk              (clk),
    .fpc_reset            (rst),
    .fpc_stall            (stall),
    .fpc_btb_valid_pred   (pred),
    .fpc_btb_target       (btb_tgt),
    .fpc_retire_valid     (r_valid),
    .fpc_retire_is_branch (r_br),
    .fpc_retire_taken     (r_taken),
    .fpc_retire_target    (r_tgt),
    .fpc_pc               (pc),
    .fpc_fetch_valid      (fv),
    .fpc_redirect         (redir),
    .fpc_btb_write        (bw),
    .fpc_btb_branch_taken (btaken),
    .fpc_btb_new_pc       (new_pc),
    .fpc_btb_data         (data)
`ifdef FPC_PERF_CNT_EN
    ,
    .fpc_branch_cnt       (br_cnt),
    .fpc_mispred_cnt      (mp_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] qcnt();
    return 32'(dut.u_fifo.cnt_q);
  endfunction

  task automatic retire(input logic v, input logic br, input logic tk, input logic [31:0] t);
    r_valid = v; r_br = br; r_taken = tk; r_tgt = t;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; pred = 1'b0; btb_tgt = '0;
    retire(0, 0, 0, '0);

    // reset state
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", 32'(fv), 32'h0);
    chk("rst_redir", 32'(redir), 32'h0);
    chk("rst_bw", 32'(bw), 32'h0);
    chk("rst_newpc", new_pc, 32'h0);
    chk("rst_data", data, 32'h0);
    chk("rst_cnt", qcnt(), 32'h0);

    // 1: sequential fetch after release
    rst = 1'b1; #1;
    chk("t1_fv_norun", 32'(fv), 32'h0);
    tick(); chk("t1_pc0", pc, 32'h0); chk("t1_fv0", 32'(fv), 32'h1);
    tick(); chk("t1_pc4", pc, 32'h4); chk("t1_fv4", 32'(fv), 32'h1);
    tick(); chk("t1_pc8", pc, 32'h8);
    // 2: predicted taken at pc 8, correct retire
    pred = 1'b1; btb_tgt = 32'h40; #1;
    chk("t2_fv8", 32'(fv), 32'h1);
    tick(); chk("t2_pc40", pc, 32'h40); chk("t2_cnt3", qcnt(), 32'h3);
    pred = 1'b0; stall = 1'b1;
    retire(1, 0, 0, '0);
    tick(); chk("t2_nb_bw", 32'(bw), 32'h0); chk("t2_cnt2", qcnt(), 32'h2);
    tick();
    retire(1, 1, 1, 32'h40); #1;
    chk("t2_fv_stall", 32'(fv), 32'h0);
    tick();
    chk("t2_bw", 32'(bw), 32'h1);
    chk("t2_newpc", new_pc, 32'h8);
    chk("t2_data", data, 32'h40);
    chk("t2_taken", 32'(btaken), 32'h1);
    chk("t2_redir", 32'(redir), 32'h0);
    chk("t2_pc_hold", pc, 32'h40);
    chk("t2_cnt0", qcnt(), 32'h0);
    retire(0, 0, 0, '0);

    // 3: predicted taken at pc 4, actually not taken
    rst = 1'b0; tick();
    rst = 1'b1; stall = 1'b0; tick(); tick();
    chk("t3_pc4", pc, 32'h4);
    pred = 1'b1; btb_tgt = 32'h80;
    tick(); chk("t3_pc80", pc, 32'h80);
    pred = 1'b0; stall = 1'b1;
    retire(1, 0, 0, '0);
    tick();
    retire(1, 1, 0, 32'h0);
    tick();
    chk("t3_redir", 32'(redir), 32'h1);
    chk("t3_pc", pc, 32'h8);
    chk("t3_cnt", qcnt(), 32'h0);
    chk("t3_bw", 32'(bw), 32'h1);
    chk("t3_taken", 32'(btaken), 32'h0);
    chk("t3_data", data, 32'h8);
    chk("t3_newpc", new_pc, 32'h4);
    retire(0, 0, 0, '0);
    tick();
    chk("t3_redir_pulse", 32'(redir), 32'h0);
    chk("t3_bw_pulse", 32'(bw), 32'h0);

    // 4: fill the queue, then push+pop while full
    stall = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t4_cnt_full", qcnt(), 32'h4);
    chk("t4_fv_full", 32'(fv), 32'h0);
    tick(); chk("t4_pc_hold", pc, 32'h18);
    retire(1, 0, 0, '0); #1;
    chk("t4_fv_pop", 32'(fv), 32'h1);
    tick();
    chk("t4_cnt_same", qcnt(), 32'h4);
    chk("t4_pc1c", pc, 32'h1C);
    retire(0, 0, 0, '0);

    // 5: mispredict under stall, then retire on empty queue
    stall = 1'b1;
    retire(1, 1, 1, 32'h200); #1;
    chk("t5_fv", 32'(fv), 32'h0);
    tick();
    chk("t5_pc", pc, 32'h200);
    chk("t5_redir", 32'(redir), 32'h1);
    chk("t5_cnt", qcnt(), 32'h0);
    chk("t5_newpc", new_pc, 32'hC);
    chk("t5_data", data, 32'h200);
    tick();
    chk("t5_empty_bw", 32'(bw), 32'h0);
    chk("t5_empty_redir", 32'(redir), 32'h0);
    chk("t5_empty_pc", pc, 32'h200);
    // redirect beats fire with no stall
    retire(0, 0, 0, '0); stall = 1'b0;
    tick(); chk("t5_pc204", pc, 32'h204);
    retire(1, 1, 1, 32'h300); #1;
    chk("t5_fv_redir", 32'(fv), 32'h0);
    tick();
    chk("t5_pc300", pc, 32'h300);
    chk("t5_cnt_flush", qcnt(), 32'h0);
    retire(0, 0, 0, '0);

    // 6: reset mid-stream with a mispredicting retire pending
    tick(); tick(); tick();
    chk("t6_cnt3", qcnt(), 32'h3);
    rst = 1'b0;
    retire(1, 1, 1, 32'h500);
    tick();
    chk("t6_pc", pc, 32'h0);
    chk("t6_cnt", qcnt(), 32'h0);
    chk("t6_bw", 32'(bw), 32'h0);
    chk("t6_redir", 32'(redir), 32'h0);
    chk("t6_fv", 32'(fv), 32'h0);
    retire(0, 0, 0, '0);

    // PC wrap at the top of the address space
    rst = 1'b1; tick();
    pred = 1'b1; btb_tgt = 32'hFFFF_FFFC;
    tick(); chk("wrap_top", pc, 32'hFFFF_FFFC);
    pred = 1'b0;
    tick(); chk("wrap_zero", pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
